// File: rtl/led_matrix_spectrum.sv
// led_matrix_spectrum
//   Shows a stream of FFT magnitude bins as a 32-band bar graph on a 32x32 HUB75 panel.
//   The panel is 1/16 scan, and its upper and lower halves are shifted in parallel.
//   Each bin is clipped to a bar height of 0..32. The heights go into a write buffer.
//   A full set of 32 heights moves to the display buffer only at the start of row 0,
//   so a frame on the panel always comes from a single buffer snapshot.
//
//   Every panel output is registered one tick after the FSM state that produces it.
//   Every visible phase therefore trails its FSM state by exactly CLK_DIV cycles.
//   The first CLK_MATRIX rise comes 2*CLK_DIV cycles after reset.
//   A row takes 66*CLK_DIV + ON_TIME cycles. ON_TIME must be larger than CLK_DIV.
//
// Ports
//   MCLK          system clock, rising edge
//   RESET         synchronous reset, active-high
//   source_valid  one-cycle strobe qualifying F_BIN_IN
//   F_BIN_IN      unsigned bin magnitude
//   RGB1 / RGB2   pixel data for row r / row r+16 (bit0=R, bit1=G, bit2=B)
//   ROW_ADDRESS   row-pair address 0..15
//   CLK_MATRIX    panel shift clock
//   LATCH         latch strobe, active-high
//   OE            output enable, active-low
//   GND           constant zero
module led_matrix_spectrum #(
    parameter int unsigned BIN_WIDTH = 24,
    parameter int unsigned MAG_SHIFT = 0,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned ON_TIME   = 64
) (
    input  logic                 MCLK,
    input  logic                 RESET,
    input  logic                 source_valid,
    input  logic [BIN_WIDTH-1:0] F_BIN_IN,
    output logic [2:0]           RGB1,
    output logic [2:0]           RGB2,
    output logic [3:0]           ROW_ADDRESS,
    output logic                 CLK_MATRIX,
    output logic                 LATCH,
    output logic                 OE,
    output logic [2:0]           GND
);

    localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OW = (ON_TIME > 1) ? $clog2(ON_TIME) : 1;

    typedef enum logic [2:0] {
        StShiftLo,
        StShiftHi,
        StBlank,
        StLatch,
        StDisplay
    } state_e;

    state_e         state_q;
    logic [4:0]     col_q;
    logic [3:0]     row_q;
    logic [TW-1:0]  tick_cnt_q;
    logic [OW-1:0]  on_cnt_q;
    logic [4:0]     bin_idx_q;
    logic           pending_q;
    logic [5:0]     write_buf_q [32];
    logic [5:0]     disp_buf_q  [32];

    logic                 tick;
    logic [BIN_WIDTH-1:0] mag_shifted;
    logic [5:0]           bin_height;

    assign GND  = 3'b000;
    assign tick = (tick_cnt_q == TW'(CLK_DIV - 1));

    always_comb begin
        mag_shifted = F_BIN_IN >> MAG_SHIFT;
        bin_height  = (mag_shifted >= BIN_WIDTH'(32)) ? 6'd32 : mag_shifted[5:0];
    end

    // A pixel at panel row y is lit when y + height >= 32.
    // The band colour depends only on y.
    function automatic logic [2:0] pixel_colour(input logic [4:0] y, input logic [5:0] h);
        logic [6:0] sum;
        sum = {2'b00, y} + {1'b0, h};
        if (sum < 7'd32)       return 3'b000;
        else if (y < 5'd8)     return 3'b001;
        else if (y < 5'd16)    return 3'b011;
        else                   return 3'b010;
    endfunction

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q     <= StShiftLo;
            col_q       <= '0;
            row_q       <= '0;
            tick_cnt_q  <= '0;
            on_cnt_q    <= '0;
            bin_idx_q   <= '0;
            pending_q   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                write_buf_q[i] <= '0;
                disp_buf_q[i]  <= '0;
            end
            RGB1        <= 3'b000;
            RGB2        <= 3'b000;
            ROW_ADDRESS <= 4'd0;
            CLK_MATRIX  <= 1'b0;
            LATCH       <= 1'b0;
            OE          <= 1'b1;
        end else begin
            if (source_valid) begin
                write_buf_q[bin_idx_q] <= bin_height;
                bin_idx_q              <= bin_idx_q + 5'd1;
            end

            // The tick counter is parked during DISPLAY.
            // The first shift tick of the next row then lasts a full CLK_DIV.
            if (state_q == StDisplay || tick) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end

            unique case (state_q)
                StShiftLo: begin
                    if (tick) begin
                        CLK_MATRIX <= 1'b0;
                        OE         <= 1'b1;   // ends the previous row's on-time
                        LATCH      <= 1'b0;
                        RGB1       <= pixel_colour({1'b0, row_q}, disp_buf_q[col_q]);
                        RGB2       <= pixel_colour({1'b1, row_q}, disp_buf_q[col_q]);
                        state_q    <= StShiftHi;
                    end
                end
                StShiftHi: begin
                    if (tick) begin
                        CLK_MATRIX <= 1'b1;
                        if (col_q == 5'd31) begin
                            col_q   <= '0;
                            state_q <= StBlank;
                        end else begin
                            col_q   <= col_q + 5'd1;
                            state_q <= StShiftLo;
                        end
                    end
                end
                StBlank: begin
                    if (tick) begin
                        CLK_MATRIX  <= 1'b0;
                        OE          <= 1'b1;
                        ROW_ADDRESS <= row_q;
                        state_q     <= StLatch;
                    end
                end
                StLatch: begin
                    if (tick) begin
                        LATCH    <= 1'b1;
                        OE       <= 1'b1;
                        on_cnt_q <= '0;
                        state_q  <= StDisplay;
                    end
                end
                StDisplay: begin
                    on_cnt_q <= on_cnt_q + 1'b1;
                    // The latch pulse is visible for one tick.
                    // After that the row is lit.
                    if (on_cnt_q == OW'(CLK_DIV - 1)) begin
                        LATCH <= 1'b0;
                        OE    <= 1'b0;
                    end
                    if (on_cnt_q == OW'(ON_TIME - 1)) begin
                        row_q   <= row_q + 4'd1;
                        state_q <= StShiftLo;
                        if (row_q == 4'd15 && pending_q) begin
                            disp_buf_q <= write_buf_q;
                            pending_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StShiftLo;
            endcase

            // Placed after the swap so a frame completing on the swap edge stays pending.
            if (source_valid && bin_idx_q == 5'd31) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_spectrum.sv
module tb_led_matrix_spectrum;

    localparam int BinWidth    = 24;
    localparam int MagShift    = 0;
    localparam int ClkDiv      = 2;
    localparam int OnTime      = 64;
    localparam int RowPeriod   = 66 * ClkDiv + OnTime;
    localparam int FramePeriod = 16 * RowPeriod;

    logic                MCLK = 1'b0;
    logic                RESET = 1'b1;
    logic                source_valid = 1'b0;
    logic [BinWidth-1:0] F_BIN_IN = '0;
    logic [2:0]          RGB1, RGB2, GND;
    logic [3:0]          ROW_ADDRESS;
    logic                CLK_MATRIX, LATCH, OE;

    led_matrix_spectrum #(
        .BIN_WIDTH (BinWidth),
        .MAG_SHIFT (MagShift),
        .CLK_DIV   (ClkDiv),
        .ON_TIME   (OnTime)
    ) dut (
        .MCLK         (MCLK),
        .RESET        (RESET),
        .source_valid (source_valid),
        .F_BIN_IN     (F_BIN_IN),
        .RGB1         (RGB1),
        .RGB2         (RGB2),
        .ROW_ADDRESS  (ROW_ADDRESS),
        .CLK_MATRIX   (CLK_MATRIX),
        .LATCH        (LATCH),
        .OE           (OE),
        .GND          (GND)
    );

    always #5 MCLK = ~MCLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  row;
        logic [95:0] rgb1;
        logic [95:0] rgb2;
    } row_exp_t;

    row_exp_t exp_q[$];
    int       n_edge = 0;           // rising edges since the last reset edge
    int       m_wbuf[32];
    int       m_disp[32];
    int       m_idx;
    bit       m_pending;

    function automatic logic [2:0] exp_colour(int y, int h);
        if (y < 32 - h) return 3'b000;
        if (y < 8)      return 3'b001;
        if (y < 16)     return 3'b011;
        return 3'b010;
    endfunction

    function automatic row_exp_t make_row(int r);
        row_exp_t e;
        e.row  = 4'(r);
        e.rgb1 = '0;
        e.rgb2 = '0;
        for (int c = 0; c < 32; c++) begin
            e.rgb1[c*3 +: 3] = exp_colour(r, m_disp[c]);
            e.rgb2[c*3 +: 3] = exp_colour(r + 16, m_disp[c]);
        end
        return e;
    endfunction

    // Row r starts at edge r*RowPeriod; the frame snapshot is taken as row 0 starts.
    always @(posedge MCLK) begin
        if (RESET) begin
            n_edge    = 0;
            m_idx     = 0;
            m_pending = 0;
            for (int i = 0; i < 32; i++) begin
                m_wbuf[i] = 0;
                m_disp[i] = 0;
            end
            exp_q.delete();
            exp_q.push_back(make_row(0));
        end else begin
            logic [BinWidth-1:0] mag;
            n_edge++;
            if (n_edge % FramePeriod == 0 && m_pending) begin
                m_disp    = m_wbuf;
                m_pending = 0;
            end
            if (source_valid) begin
                mag           = F_BIN_IN >> MagShift;
                m_wbuf[m_idx] = (mag > 32) ? 32 : int'(mag);
                if (m_idx == 31) m_pending = 1;
                m_idx = (m_idx + 1) % 32;
            end
            if (n_edge % RowPeriod == 0) exp_q.push_back(make_row((n_edge / RowPeriod) % 16));
        end
    end

    // ---------------- monitor ----------------
    logic        clk_prev, latch_prev, oe_prev;
    int          col_cnt, latch_start, last_latch, oe_fall;
    int          rows_checked = 0;
    bit          first_rise;
    logic [95:0] cap1, cap2;

    always @(negedge MCLK) begin
        if (RESET) begin
            clk_prev    = 1'b0;
            latch_prev  = 1'b0;
            oe_prev     = 1'b1;
            col_cnt     = 0;
            latch_start = -1;
            last_latch  = -1;
            oe_fall     = -1;
            first_rise  = 1;
            cap1        = '0;
            cap2        = '0;
        end else begin
            if (CLK_MATRIX && !clk_prev) begin
                if (first_rise) begin
                    check("first_clk_rise", 128'(n_edge), 128'(2 * ClkDiv));
                    first_rise = 0;
                end
                if (col_cnt < 32) begin
                    cap1[col_cnt*3 +: 3] = RGB1;
                    cap2[col_cnt*3 +: 3] = RGB2;
                end
                col_cnt++;
            end
            if (LATCH && !latch_prev) begin
                row_exp_t e;
                check("shift_clocks_per_row", 128'(col_cnt), 128'(32));
                check("oe_blank_at_latch", 128'(OE), 128'(1));
                if (last_latch >= 0)
                    check("row_period", 128'(n_edge - last_latch), 128'(RowPeriod));
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty: latch seen with no expected row queued");
                end else begin
                    e = exp_q.pop_front();
                    check("row_address", 128'(ROW_ADDRESS), 128'(e.row));
                    check("rgb1_row", 128'(cap1), 128'(e.rgb1));
                    check("rgb2_row", 128'(cap2), 128'(e.rgb2));
                end
                rows_checked++;
                col_cnt     = 0;
                last_latch  = n_edge;
                latch_start = n_edge;
            end
            if (!LATCH && latch_prev && latch_start >= 0)
                check("latch_width", 128'(n_edge - latch_start), 128'(ClkDiv));
            if (!OE && oe_prev) begin
                oe_fall = n_edge;
                check("latch_low_when_lit", 128'(LATCH), 128'(0));
            end
            if (OE && !oe_prev && oe_fall >= 0)
                check("oe_low_time", 128'(n_edge - oe_fall), 128'(OnTime));
            clk_prev   = CLK_MATRIX;
            latch_prev = LATCH;
            oe_prev    = OE;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic send_bin(input logic [BinWidth-1:0] v);
        source_valid = 1'b1;
        F_BIN_IN     = v;
        cycles(1);
        source_valid = 1'b0;
    endtask

    function automatic logic [BinWidth-1:0] rand_mag();
        if ($urandom_range(0, 3) == 0) return BinWidth'($urandom);
        return BinWidth'($urandom_range(0, 34));
    endfunction

    initial begin
        int guard;
        RESET        = 1'b1;
        source_valid = 1'b0;
        F_BIN_IN     = '0;
        repeat (10) @(posedge MCLK);
        @(negedge MCLK);
        check("reset_oe", 128'(OE), 128'(1));
        check("reset_latch", 128'(LATCH), 128'(0));
        check("reset_clk_matrix", 128'(CLK_MATRIX), 128'(0));
        check("reset_rgb1", 128'(RGB1), 128'(0));
        check("reset_rgb2", 128'(RGB2), 128'(0));
        check("reset_row_address", 128'(ROW_ADDRESS), 128'(0));
        check("reset_gnd", 128'(GND), 128'(0));
        @(posedge MCLK);
        #1 RESET = 1'b0;

        // Ramp of heights 1..32, one bin every 64 cycles.
        for (int b = 1; b <= 32; b++) begin
            send_bin(BinWidth'(b));
            cycles(63);
        end
        cycles(2 * FramePeriod);

        // Saturated bins light every pixel.
        for (int b = 0; b < 32; b++) send_bin({BinWidth{1'b1}});
        cycles(2 * FramePeriod);

        // Random magnitudes with random gaps.
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 32; b++) begin
                send_bin(rand_mag());
                cycles($urandom_range(0, 20));
            end
            cycles(FramePeriod);
        end

        // A half-written frame must not reach the display.
        for (int b = 0; b < 16; b++) send_bin(rand_mag());
        cycles(FramePeriod);
        for (int b = 0; b < 16; b++) send_bin(BinWidth'($urandom_range(8, 32)));
        cycles(2 * FramePeriod);

        // Reset during the on-time of row 7.
        guard = 0;
        while ((n_edge % FramePeriod) != 7 * RowPeriod + 150 && guard < 2 * FramePeriod) begin
            cycles(1);
            guard++;
        end
        check("row7_display_reached", 128'(guard < 2 * FramePeriod), 128'(1));
        check("oe_active_before_reset", 128'(OE), 128'(0));
        RESET = 1'b1;
        cycles(1);
        RESET = 1'b0;
        check("midreset_oe", 128'(OE), 128'(1));
        check("midreset_row_address", 128'(ROW_ADDRESS), 128'(0));
        check("midreset_rgb1", 128'(RGB1), 128'(0));
        check("midreset_rgb2", 128'(RGB2), 128'(0));
        cycles(FramePeriod + RowPeriod);

        check("rows_checked_min", 128'(rows_checked >= 150), 128'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
